// File: rtl/video_pkg.sv
// Shared video types and constants for the layer compositor and its pixel stages.
package video_pkg;

  localparam int DEFAULT_COLOR_BITS = 4;
  localparam int MAX_LAYERS         = 8;

  typedef struct packed {
    logic [DEFAULT_COLOR_BITS-1:0] r;
    logic [DEFAULT_COLOR_BITS-1:0] g;
    logic [DEFAULT_COLOR_BITS-1:0] b;
  } rgb_t;

  // Idle level of a sync line: high when the sync pulse is active-low.
  function automatic logic sync_deassert(input logic sync_active_low);
    return sync_active_low;
  endfunction

endpackage

// File: rtl/mixer_stage.sv
// One compositing register stage: a covering layer replaces (or, with BLEND, averages
// with) the accumulated colour; otherwise the accumulator passes through.
module mixer_stage
  import video_pkg::*;
#(
  parameter int COLOR_BITS = DEFAULT_COLOR_BITS,
  parameter bit BLEND      = 1'b0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [3*COLOR_BITS-1:0] acc_i,
  input  logic [3*COLOR_BITS-1:0] layer_i,
  input  logic                    cover_i,
  output logic [3*COLOR_BITS-1:0] acc_o
);

  localparam int CW = 3*COLOR_BITS;

  logic [CW-1:0] mixed;
  logic [CW-1:0] acc_d, acc_q;

  if (BLEND) begin : g_blend
    // Sum in COLOR_BITS+1 bits, halve, truncate: rounds down.
    always_comb begin
      mixed = '0;
      for (int c = 0; c < 3; c++) begin
        mixed[c*COLOR_BITS +: COLOR_BITS] =
          COLOR_BITS'(({1'b0, layer_i[c*COLOR_BITS +: COLOR_BITS]} +
                       {1'b0, acc_i[c*COLOR_BITS +: COLOR_BITS]}) >> 1);
      end
    end
  end else begin : g_replace
    assign mixed = layer_i;
  end

  always_comb begin
    acc_d = acc_i;
    if (cover_i) acc_d = mixed;
  end

  always_ff @(posedge clk) begin
    if (reset) acc_q <= '0;
    else       acc_q <= acc_d;
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/layer_mixer.sv
// Fixed-priority RGB layer compositor with sync/active delay lines and a per-frame visibility latch.
// Define LAYER_MIXER_BLEND_EN to average the top layer 50/50 with the layers beneath it.
module layer_mixer
  import video_pkg::*;
#(
  parameter int                         NUM_LAYERS      = 4,
  parameter int                         COLOR_BITS      = DEFAULT_COLOR_BITS,
  parameter logic [3*COLOR_BITS-1:0]    BACKDROP_RGB    = '0,
  parameter bit                         SYNC_ACTIVE_LOW = 1'b1,
  parameter logic [NUM_LAYERS-1:0]      VIS_RESET       = '1
) (
  input  logic                             clkPixel,
  input  logic                             reset,
  input  logic [NUM_LAYERS*COLOR_BITS-1:0] layerRed,
  input  logic [NUM_LAYERS*COLOR_BITS-1:0] layerGreen,
  input  logic [NUM_LAYERS*COLOR_BITS-1:0] layerBlue,
  input  logic [NUM_LAYERS-1:0]            layerOpaque,
  input  logic [NUM_LAYERS-1:0]            layersVisible,
  input  logic                             videoActive,
  input  logic                             hsync,
  input  logic                             vsync,
  output logic [COLOR_BITS-1:0]            red,
  output logic [COLOR_BITS-1:0]            green,
  output logic [COLOR_BITS-1:0]            blue,
  output logic                             hsyncOut,
  output logic                             vsyncOut,
  output logic                             videoActiveOut
);

  localparam int       CW        = 3*COLOR_BITS;
  localparam logic     SYNC_IDLE = sync_deassert(SYNC_ACTIVE_LOW);
  localparam bit [2:0] CTL_IDLE  = {1'b0, SYNC_IDLE, SYNC_IDLE};
`ifdef LAYER_MIXER_BLEND_EN
  localparam bit BLEND_TOP = 1'b1;
`else
  localparam bit BLEND_TOP = 1'b0;
`endif

  // Control bundle is {videoActive, hsync, vsync}.
  logic                            vs_hist_d, vs_hist_q;
  logic [NUM_LAYERS-1:0]           vis_d, vis_q;
  logic                            vs_edge;
  logic [NUM_LAYERS-1:0][CW-1:0]   lay_d, lay_q;
  logic [NUM_LAYERS-1:0]           cover_d, cover_q;
  logic [2:0]                      ctl0_d, ctl0_q;
  logic [NUM_LAYERS-1:0][2:0]      ctl_d, ctl_q;
  logic [NUM_LAYERS-1:0][CW:0]     lay_at_stage;
  logic [NUM_LAYERS:0][CW-1:0]     acc;
  logic [CW-1:0]                   rgb_d, rgb_q;
  logic [2:0]                      ctl_out_d, ctl_out_q;

  // The pixel sampled on the vsync edge already uses the freshly latched mask.
  always_comb begin
    vs_hist_d = vsync ^ SYNC_ACTIVE_LOW;
    vs_edge   = vs_hist_d & ~vs_hist_q;
    vis_d     = vs_edge ? layersVisible : vis_q;
    cover_d   = vis_d & layerOpaque;
    ctl0_d    = {videoActive, hsync, vsync};
    for (int i = 0; i < NUM_LAYERS; i++) begin
      lay_d[i] = {layerRed[i*COLOR_BITS +: COLOR_BITS],
                  layerGreen[i*COLOR_BITS +: COLOR_BITS],
                  layerBlue[i*COLOR_BITS +: COLOR_BITS]};
    end
    ctl_d[0] = ctl0_q;
    for (int j = 1; j < NUM_LAYERS; j++) ctl_d[j] = ctl_q[j-1];
  end

  always_ff @(posedge clkPixel) begin
    if (reset) begin
      vs_hist_q <= 1'b0;
      vis_q     <= VIS_RESET;
      lay_q     <= '0;
      cover_q   <= '0;
      ctl0_q    <= CTL_IDLE;
      ctl_q     <= {NUM_LAYERS{CTL_IDLE}};
    end else begin
      vs_hist_q <= vs_hist_d;
      vis_q     <= vis_d;
      lay_q     <= lay_d;
      cover_q   <= cover_d;
      ctl0_q    <= ctl0_d;
      ctl_q     <= ctl_d;
    end
  end

  assign acc[0] = BACKDROP_RGB;

  for (genvar i = 0; i < NUM_LAYERS; i++) begin : g_layer
    if (i == 0) begin : g_direct
      assign lay_at_stage[i] = {cover_q[i], lay_q[i]};
    end else begin : g_delay
      // Layer i waits i cycles so it meets the accumulator at stage i+1.
      logic [i-1:0][CW:0] dly_d, dly_q;
      always_comb begin
        dly_d[0] = {cover_q[i], lay_q[i]};
        for (int j = 1; j < i; j++) dly_d[j] = dly_q[j-1];
      end
      always_ff @(posedge clkPixel) begin
        if (reset) dly_q <= '0;
        else       dly_q <= dly_d;
      end
      assign lay_at_stage[i] = dly_q[i-1];
    end

    mixer_stage #(
      .COLOR_BITS (COLOR_BITS),
      .BLEND      (BLEND_TOP && (i == NUM_LAYERS-1))
    ) u_stage (
      .clk     (clkPixel),
      .reset   (reset),
      .acc_i   (acc[i]),
      .layer_i (lay_at_stage[i][CW-1:0]),
      .cover_i (lay_at_stage[i][CW]),
      .acc_o   (acc[i+1])
    );
  end

  always_comb begin
    ctl_out_d = ctl_q[NUM_LAYERS-1];
    rgb_d     = ctl_out_d[2] ? acc[NUM_LAYERS] : '0;
  end

  always_ff @(posedge clkPixel) begin
    if (reset) begin
      rgb_q     <= '0;
      ctl_out_q <= CTL_IDLE;
    end else begin
      rgb_q     <= rgb_d;
      ctl_out_q <= ctl_out_d;
    end
  end

  assign red            = rgb_q[2*COLOR_BITS +: COLOR_BITS];
  assign green          = rgb_q[COLOR_BITS +: COLOR_BITS];
  assign blue           = rgb_q[0 +: COLOR_BITS];
  assign videoActiveOut = ctl_out_q[2];
  assign hsyncOut       = ctl_out_q[1];
  assign vsyncOut       = ctl_out_q[0];

endmodule

// File: doc/layer_mixer.md
Name: layer_mixer

Overview:
- Parametrised pixel compositor between the per-layer pixel generators (background, sprites, text) and the video DAC pins.
- Accepts NUM_LAYERS RGB layers, each with a 1-bit opaque flag. Composites them in fixed priority: layer 0 at the bottom, layer NUM_LAYERS-1 on top, over a backdrop colour.
- Delays hsync, vsync and videoActive by the pipeline latency, so the frame generator's PIPELINE_DELAY only has to include this block's fixed latency.
- The layer-visibility mask is latched once per frame, so a mid-frame mask change never tears the image.

Parameters:
- NUM_LAYERS, 4, number of input layers (1..8).
- COLOR_BITS, 4, bits per colour channel.
- BACKDROP_RGB, 12'h000, backdrop colour {R,G,B}, each channel COLOR_BITS wide. Width is 3*COLOR_BITS.
- SYNC_ACTIVE_LOW, 1, 1 = hsync/vsync asserted low, 0 = asserted high.
- VIS_RESET, all ones, reset value of the latched visibility mask. Width is NUM_LAYERS.

Ports:
- clkPixel  in  1  pixel clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- layerRed  in  NUM_LAYERS*COLOR_BITS  red channel per layer; layer i occupies bits [i*COLOR_BITS +: COLOR_BITS].
- layerGreen  in  NUM_LAYERS*COLOR_BITS  green channel per layer, same packing as layerRed.
- layerBlue  in  NUM_LAYERS*COLOR_BITS  blue channel per layer, same packing as layerRed.
- layerOpaque  in  NUM_LAYERS  1 = the layer's pixel covers everything below it.
- layersVisible  in  NUM_LAYERS  requested visibility mask; latched at frame start.
- videoActive  in  1  input pixel is inside the visible area.
- hsync  in  1  horizontal sync, aligned with the pixel inputs.
- vsync  in  1  vertical sync, aligned with the pixel inputs.
- red  out  COLOR_BITS  composited red.
- green  out  COLOR_BITS  composited green.
- blue  out  COLOR_BITS  composited blue.
- hsyncOut  out  1  hsync delayed by LATENCY.
- vsyncOut  out  1  vsync delayed by LATENCY.
- videoActiveOut  out  1  videoActive delayed by LATENCY.

Behaviour:
- Reset is synchronous and active-high on clkPixel. Reset values:
  - red, green, blue = 0.
  - videoActiveOut = 0.
  - hsyncOut, vsyncOut = the deasserted level (1 if SYNC_ACTIVE_LOW, else 0).
  - all pipeline registers = 0 / deasserted.
  - visMask = VIS_RESET.
  - vsync edge detector history = deasserted.
- Latency: LATENCY = NUM_LAYERS+1 cycles, fixed and data-independent. Inputs sampled on edge n appear on the outputs after edge n+LATENCY.
- Pipeline structure:
  - Stage 0 registers all inputs.
  - Stage k (1..NUM_LAYERS) composites layer k-1 over the accumulated colour.
  - The stage NUM_LAYERS result is the output register.
- Initial accumulator = BACKDROP_RGB.
- Stage k rule: if visMask[k-1] && layerOpaque[k-1], acc = layer k-1 colour; otherwise acc passes unchanged. Layer data for layer k-1 is delayed k-1 extra cycles so it meets its stage.
- Blanking: if the delayed videoActive is 0 at the output stage, red/green/blue = 0 regardless of layers and backdrop.
- visMask update:
  - visMask <= layersVisible on the first cycle vsync becomes asserted (edge relative to the previous sampled vsync).
  - The new mask applies to pixels sampled from that cycle onward.
  - Pixels already in the pipeline keep the mask that was current when they entered stage 0.
- Mask changes without a vsync edge have no effect.
- vsync held asserted continuously: a single update only.
- Reset asserted mid-frame: the pipeline flushes immediately. Outputs hold reset values for LATENCY cycles after reset deasserts, until valid data drains through.
- Stage 0 applies no combinational path from inputs to outputs.
- NUM_LAYERS=1 is legal: LATENCY = 2.

Optional Feature:
- Macro LAYER_MIXER_BLEND_EN.
- When defined: the top layer (NUM_LAYERS-1), when visible and opaque, is averaged 50/50 with the accumulated colour instead of replacing it.
  - Per channel: (top + acc) >> 1, computed in COLOR_BITS+1 bits and truncated (rounds down).
  - Latency is unchanged.
- When undefined: the top layer uses the normal replace rule, and no adder logic is instantiated.

Decomposition:
- Package video_pkg holds:
  - COLOR_BITS default constant.
  - rgb_t packed struct {r,g,b}.
  - sync_deassert(SYNC_ACTIVE_LOW) helper function.
  - MAX_LAYERS = 8 constant.
- One sub-module, mixer_stage: a one-layer compare/replace (or blend) register stage. Instantiated NUM_LAYERS times via generate; parameterised with a BLEND bit that is set only on the top stage under the macro.
- Sync/active delay lines and the visMask latch stay in layer_mixer.

Test Plan:
- Reset then idle, videoActive=0: red/green/blue=0, hsyncOut=vsyncOut=1, videoActiveOut=0 for all cycles.
- NUM_LAYERS=4, all opaque, visMask=4'hF, layer colours 0x111/0x222/0x333/0x444: output 0x444 exactly 5 cycles after input. Clear layerOpaque[3]: output becomes 0x333.
- No opaque layers, BACKDROP_RGB=12'h00F, videoActive=1: output 0x00F. Drop videoActive: output 0x000 with videoActiveOut falling on the same cycle.
- Change layersVisible to 4'h7 mid-frame: output still 0x444 until the vsync edge. First pixel sampled at or after the edge shows 0x333.
- Pulse reset for 1 cycle mid-line: next output edge gives reset values. Valid colour resumes 5 cycles after deassertion.
- With LAYER_MIXER_BLEND_EN, layer3 = 0xF00 over layer2 = 0x0F0: output 0x770.
